// File: rtl/pipelined_accumulator.sv
// Streaming add/accumulate stage: r = (ACC_EN ? acc : I0) + I1, delivered through
// DEPTH valid/ready pipeline stages with optional unsigned saturation.
module pipelined_accumulator #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 2,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic             ACC_EN,
    input  logic             ACC_CLR,
    output logic [WIDTH-1:0] O,
    output logic             CO,
    output logic             O_VALID,
    input  logic             O_READY
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic             co_q   [DEPTH];
    logic             vld_q  [DEPTH];
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    logic             advance;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] res;

    // The whole pipe shifts together; only a stalled, valid output stage blocks it.
    assign advance = O_READY || !vld_q[DEPTH-1];
    assign I_READY = advance;

    always_comb begin
        acc_eff = ACC_CLR ? '0 : acc_q;
        op_a    = ACC_EN ? acc_eff : I0;
        sum     = {1'b0, op_a} + {1'b0, I1};
        carry   = sum[WIDTH];
        res     = (SATURATE && carry) ? '1 : sum[WIDTH-1:0];
    end

    always_comb begin
        acc_d = acc_q;
        if (I_VALID && advance && ACC_EN) begin
            acc_d = res;
        end else if (ACC_CLR) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            acc_q     <= '0;
            data_q[0] <= '0;
            co_q[0]   <= 1'b0;
            vld_q[0]  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (advance) begin
                data_q[0] <= res;
                co_q[0]   <= carry;
                vld_q[0]  <= I_VALID;
            end
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) begin
                data_q[g] <= '0;
                co_q[g]   <= 1'b0;
                vld_q[g]  <= 1'b0;
            end else if (advance) begin
                data_q[g] <= data_q[g-1];
                co_q[g]   <= co_q[g-1];
                vld_q[g]  <= vld_q[g-1];
            end
        end
    end

    assign O       = data_q[DEPTH-1];
    assign CO      = co_q[DEPTH-1];
    assign O_VALID = vld_q[DEPTH-1];

endmodule

// File: tb/tb_pipelined_accumulator.sv
// Bench for pipelined_accumulator: two configurations share one stimulus stream and are
// scored every cycle against a queue-based model, plus directed literal checks.
module tb_pipelined_accumulator;

    localparam int WA = 32, DA = 2;
    localparam int WB = 8,  DB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i0, i1;
    logic        i_valid, acc_en, acc_clr, o_ready;

    logic [31:0] a_o;
    logic        a_co, a_ov, a_ir;
    logic [7:0]  b_o;
    logic        b_co, b_ov, b_ir;

    always #5 clk = ~clk;

    pipelined_accumulator #(.WIDTH(WA), .DEPTH(DA), .SATURATE(1'b0)) u_a (
        .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0), .I1(i1), .I_VALID(i_valid), .I_READY(a_ir),
        .ACC_EN(acc_en), .ACC_CLR(acc_clr), .O(a_o), .CO(a_co), .O_VALID(a_ov), .O_READY(o_ready)
    );

    pipelined_accumulator #(.WIDTH(WB), .DEPTH(DB), .SATURATE(1'b1)) u_b (
        .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0[7:0]), .I1(i1[7:0]), .I_VALID(i_valid), .I_READY(b_ir),
        .ACC_EN(acc_en), .ACC_CLR(acc_clr), .O(b_o), .CO(b_co), .O_VALID(b_ov), .O_READY(o_ready)
    );

    typedef struct { logic [63:0] r; bit c; int tag; int cyc; } ent_t;
    typedef struct { logic [63:0] o; bit co; int lat; } rcv_t;

    ent_t qa[$], qb[$];
    rcv_t ra[$], rb[$];
    logic [63:0] acc_a, acc_b;
    int adv_a, adv_b;
    int cyc = 0;
    int n_vec = 0, n_err = 0;
    int ba, bb, k, waited;
    bit took;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Unsigned add at width w; returns the result and the carry out.
    function automatic logic [63:0] model_add(input int w, input bit sat,
                                              input logic [63:0] a, input logic [63:0] b,
                                              output bit c);
        logic [63:0] mask, sum, res;
        mask = (64'd1 << w) - 64'd1;
        sum  = (a & mask) + (b & mask);
        c    = ((sum >> w) != 64'd0);
        res  = sum & mask;
        if (sat && c) res = mask;
        return res;
    endfunction

    always @(negedge clk) begin
        ent_t e;
        rcv_t rv;
        logic [63:0] r, opa;
        bit c;
        cyc++;
        if (!rst_n) begin
            chk("A_rst_O", a_o, 0);  chk("A_rst_CO", a_co, 0);  chk("A_rst_VALID", a_ov, 0);
            chk("B_rst_O", b_o, 0);  chk("B_rst_CO", b_co, 0);  chk("B_rst_VALID", b_ov, 0);
            qa.delete(); qb.delete();
            acc_a = 0; acc_b = 0; adv_a = 0; adv_b = 0;
        end else begin
            // Configuration A
            chk("A_O_VALID", a_ov, (qa.size() > 0 && adv_a >= qa[0].tag));
            chk("A_I_READY", a_ir, o_ready || !a_ov);
            if (a_ov && qa.size() > 0) begin
                chk("A_O", a_o, qa[0].r);
                chk("A_CO", a_co, qa[0].c);
                if (o_ready) begin
                    rv.o = a_o; rv.co = a_co; rv.lat = cyc - qa[0].cyc;
                    ra.push_back(rv);
                    void'(qa.pop_front());
                end
            end
            if (a_ir) adv_a++;
            opa = acc_en ? (acc_clr ? 64'd0 : acc_a) : {32'd0, i0};
            r = model_add(WA, 1'b0, opa, {32'd0, i1}, c);
            if (i_valid && a_ir) begin
                e.r = r; e.c = c; e.tag = adv_a + DA - 1; e.cyc = cyc;
                qa.push_back(e);
            end
            if (i_valid && a_ir && acc_en) acc_a = r;
            else if (acc_clr) acc_a = 0;

            // Configuration B
            chk("B_O_VALID", b_ov, (qb.size() > 0 && adv_b >= qb[0].tag));
            chk("B_I_READY", b_ir, o_ready || !b_ov);
            if (b_ov && qb.size() > 0) begin
                chk("B_O", b_o, qb[0].r);
                chk("B_CO", b_co, qb[0].c);
                if (o_ready) begin
                    rv.o = b_o; rv.co = b_co; rv.lat = cyc - qb[0].cyc;
                    rb.push_back(rv);
                    void'(qb.pop_front());
                end
            end
            if (b_ir) adv_b++;
            opa = acc_en ? (acc_clr ? 64'd0 : acc_b) : {56'd0, i0[7:0]};
            r = model_add(WB, 1'b1, opa, {56'd0, i1[7:0]}, c);
            if (i_valid && b_ir) begin
                e.r = r; e.c = c; e.tag = adv_b + DB - 1; e.cyc = cyc;
                qb.push_back(e);
            end
            if (i_valid && b_ir && acc_en) acc_b = r;
            else if (acc_clr) acc_b = 0;
        end
    end

    task automatic beat(input bit v, input logic [31:0] x0, input logic [31:0] x1,
                        input bit en, input bit clr);
        i_valid = v; i0 = x0; i1 = x1; acc_en = en; acc_clr = clr;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        i_valid = 0; acc_en = 0; acc_clr = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic lit_a(input string nm, input int idx, input logic [63:0] o, input bit co);
        if (idx < ra.size()) begin
            chk({nm, "_O"}, ra[idx].o, o);
            chk({nm, "_CO"}, ra[idx].co, co);
        end else chk({nm, "_missing"}, ra.size(), idx + 1);
    endtask

    task automatic lit_b(input string nm, input int idx, input logic [63:0] o, input bit co);
        if (idx < rb.size()) begin
            chk({nm, "_O"}, rb[idx].o, o);
            chk({nm, "_CO"}, rb[idx].co, co);
        end else chk({nm, "_missing"}, rb.size(), idx + 1);
    endtask

    initial begin
        rst_n = 0; i0 = 0; i1 = 0; i_valid = 0; acc_en = 0; acc_clr = 0; o_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Plain add, streaming
        ba = ra.size(); bb = rb.size();
        beat(1, 5, 7, 0, 0);
        beat(1, 100, 1, 0, 0);
        beat(1, 32'hFFFF_FFFF, 2, 0, 0);
        idle(6);
        lit_a("add0", ba, 12, 0);
        lit_a("add1", ba + 1, 101, 0);
        lit_a("add2", ba + 2, 1, 1);
        for (int i = 0; i < 3; i++)
            if (ba + i < ra.size()) chk("add_latency", ra[ba + i].lat, DA);
        lit_b("addB2", bb + 2, 255, 1);

        // Accumulate
        beat(0, 0, 0, 0, 1);
        ba = ra.size(); bb = rb.size();
        beat(1, 0, 3, 1, 0);
        beat(1, 0, 4, 1, 0);
        beat(1, 0, 5, 1, 0);
        beat(1, 10, 1, 0, 0);
        beat(1, 0, 1, 1, 0);
        idle(6);
        lit_a("acc0", ba, 3, 0);
        lit_a("acc1", ba + 1, 7, 0);
        lit_a("acc2", ba + 2, 12, 0);
        lit_a("acc3", ba + 3, 11, 0);
        lit_a("acc4", ba + 4, 13, 0);
        lit_b("accB4", bb + 4, 13, 0);

        // Saturation (B) and wrap of the same beats (A)
        beat(0, 0, 0, 0, 1);
        ba = ra.size(); bb = rb.size();
        beat(1, 0, 200, 1, 0);
        beat(1, 0, 100, 1, 0);
        beat(1, 0, 1, 1, 0);
        beat(1, 0, 9, 1, 1);
        idle(6);
        lit_b("sat0", bb, 200, 0);
        lit_b("sat1", bb + 1, 255, 1);
        lit_b("sat2", bb + 2, 255, 1);
        lit_b("sat3", bb + 3, 9, 0);
        lit_a("wide2", ba + 2, 301, 0);

        // Backpressure: 1..10 through B with random O_READY
        bb = rb.size();
        for (k = 1; k <= 10; k++) begin
            i_valid = 1; i0 = 0; i1 = k; acc_en = 0; acc_clr = 0;
            took = 0; waited = 0;
            while (!took && waited < 60) begin
                o_ready = ($urandom_range(0, 1) == 1);
                #3 took = b_ir;
                @(posedge clk); #1;
                waited++;
            end
            if (!took) chk("bp_accept_timeout", waited, 0);
        end
        i_valid = 0;
        repeat (10) begin o_ready = ($urandom_range(0, 1) == 1); @(posedge clk); #1; end
        o_ready = 1;
        idle(8);
        chk("bp_count", rb.size() - bb, 10);
        for (int i = 0; i < 10; i++) lit_b("bp", bb + i, i + 1, 0);

        // Clear while stalled with no beat offered
        beat(0, 0, 0, 0, 1);
        ba = ra.size();
        o_ready = 0;
        beat(1, 0, 50, 1, 0);
        idle(4);
        beat(0, 0, 0, 0, 1);
        o_ready = 1;
        idle(4);
        beat(1, 0, 7, 1, 0);
        idle(6);
        lit_a("stall0", ba, 50, 0);
        lit_a("stall1", ba + 1, 7, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i0      = $urandom;
            i1      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
            acc_en  = ($urandom_range(0, 1) == 1);
            acc_clr = ($urandom_range(0, 9) == 0);
            o_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        o_ready = 1;
        idle(6);

        // Asynchronous reset with beats in flight
        beat(1, 1, 1, 0, 0);
        beat(1, 2, 2, 0, 0);
        i_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("async_A_O", a_o, 0);     chk("async_A_CO", a_co, 0);  chk("async_A_VALID", a_ov, 0);
        chk("async_B_VALID", b_ov, 0);
        @(posedge clk); #1 rst_n = 1;
        ba = ra.size(); bb = rb.size();
        idle(6);
        chk("no_stale_A", ra.size() - ba, 0);
        chk("no_stale_B", rb.size() - bb, 0);

        // Final drain
        o_ready = 1; i_valid = 0;
        waited = 0;
        while ((qa.size() + qb.size()) != 0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("drain", qa.size() + qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
